window_9_reg: RTL and testbench



---
 rtl/window_9_reg.sv | 223 ++++++++++++++++++++++
 tb/tb_window_9_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_9_reg.sv
// window_9_reg: raster pixel stream into a 4-bank line buffer, scanned out as
// 3x3 window words (row/col, boundary-pass flags, 72-bit data) for padding.
module window_9_reg #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 640
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [109:0] to_pad,
    output logic         out_valid,
    output logic         frame_done,
    output logic [1:0]   dbg_state
);
    localparam int CW = 16;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] W_LAST   = CW'(IMG_W - 1);
    localparam logic [CW-1:0] T_RD_END = CW'(IMG_W);
    localparam logic [CW-1:0] LAST_T   = CW'(IMG_W + 2);
    localparam logic [CW-1:0] R_LAST   = CW'(IMG_H - 3);
    localparam logic [CW-1:0] H_ROWS   = CW'(IMG_H);
    localparam logic [14:0]   C_LAST   = 15'(IMG_W - 3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wr_col_q, wr_col_d;
    logic [CW-1:0]   rows_written_q, rows_written_d;
    logic [CW-1:0]   r_base_q, r_base_d;
    logic [CW-1:0]   row_q, row_d;
    logic            zero_row_q, zero_row_d;
    logic            final_row_q, final_row_d;
    logic            frame_end_q, frame_end_d;
    logic [CW-1:0]   t_q, t_d;
    logic [23:0]     rd_q, rd_d;
    logic [23:0]     w0_q, w0_d;
    logic [23:0]     w1_q, w1_d;
    logic [109:0]    to_pad_q, to_pad_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            pix_ready_q, pix_ready_d;

    logic [7:0]      line_mem [4][IMG_W];
    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   rd_col;
    logic            pass_ready;
    logic            zc, fc;
    logic [14:0]     c_val;
    logic [1:0]      bank_top, bank_mid, bank_bot;
    logic [23:0]     top_row, mid_row, bot_row;

    // Input handshake: a pixel transfers on a rising edge where pix_valid & pix_ready;
    // pix_ready is registered and never depends on pix_valid.
    assign wr_en    = pix_valid & pix_ready_q;
    assign bank_top = row_q[1:0];
    assign bank_mid = row_q[1:0] + 2'd1;
    assign bank_bot = row_q[1:0] + 2'd2;
    // rd_q is the newest (rightmost) column; w0_q the leftmost.
    assign top_row  = {w0_q[23:16], w1_q[23:16], rd_q[23:16]};
    assign mid_row  = {w0_q[15:8],  w1_q[15:8],  rd_q[15:8]};
    assign bot_row  = {w0_q[7:0],   w1_q[7:0],   rd_q[7:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[rows_written_q[1:0]][wr_col_q[AW-1:0]] <= pix_in;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_col_d       = wr_col_q;
        rows_written_d = rows_written_q;
        r_base_d       = r_base_q;
        row_d          = row_q;
        zero_row_d     = zero_row_q;
        final_row_d    = final_row_q;
        frame_end_d    = frame_end_q;
        t_d            = t_q;
        rd_d           = rd_q;
        w0_d           = w0_q;
        w1_d           = w1_q;
        to_pad_d       = to_pad_q;
        out_valid_d    = 1'b0;
        frame_done_d   = 1'b0;
        rd_en          = 1'b0;
        rd_col         = '0;
        zc             = 1'b0;
        fc             = 1'b0;
        c_val          = '0;
        pass_ready     = rows_written_q >= (row_q + 16'd3);

        if (wr_en) begin
            if (wr_col_q == W_LAST) begin
                wr_col_d       = '0;
                rows_written_d = rows_written_q + 16'd1;
            end else begin
                wr_col_d = wr_col_q + 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pass_ready) begin
                    state_d = SCAN;
                    t_d     = '0;
                end
            end
            SCAN: begin
                t_d = t_q + 16'd1;
                // Column reads skip t=3 and stop after t=IMG_W so the duplicate
                // c=0 and c=IMG_W-3 windows see an unchanged window register.
                if (t_q <= 16'd2) begin
                    rd_en  = 1'b1;
                    rd_col = AW'(t_q);
                end else if (t_q >= 16'd4 && t_q <= T_RD_END) begin
                    rd_en  = 1'b1;
                    rd_col = AW'(t_q - 16'd1);
                end
                if (t_q != 16'd3 && t_q <= T_RD_END) begin
                    w0_d = w1_q;
                    w1_d = rd_q;
                end
                if (t_q >= 16'd3) begin
                    zc    = (t_q != 16'd3);
                    fc    = (t_q == LAST_T);
                    c_val = !zc ? 15'd0 : (fc ? C_LAST : 15'(t_q - 16'd4));
                    out_valid_d  = 1'b1;
                    frame_done_d = final_row_q & fc;
                    to_pad_d = {row_q[14:0], c_val, 4'b0000, zero_row_q, final_row_q,
                                zc, fc, top_row, mid_row, bot_row};
                end
                if (t_q == LAST_T) begin
                    state_d = GAP;
                    if (!zero_row_q) begin
                        zero_row_d = 1'b1;
                    end else if (final_row_q) begin
                        row_d       = '0;
                        zero_row_d  = 1'b0;
                        final_row_d = 1'b0;
                        frame_end_d = 1'b1;
                    end else if (row_q == R_LAST) begin
                        final_row_d = 1'b1;
                    end else begin
                        row_d    = row_q + 16'd1;
                        r_base_d = row_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (frame_end_q) begin
                    state_d        = IDLE;
                    frame_end_d    = 1'b0;
                    rows_written_d = '0;
                    r_base_d       = '0;
                    wr_col_d       = '0;
                end else if (pass_ready) begin
                    state_d = SCAN;
                    t_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_en) begin
            rd_d = {line_mem[bank_top][rd_col], line_mem[bank_mid][rd_col],
                    line_mem[bank_bot][rd_col]};
        end

        pix_ready_d = ((rows_written_d - r_base_d) < 16'd4) && (rows_written_d < H_ROWS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_col_q       <= '0;
            rows_written_q <= '0;
            r_base_q       <= '0;
            row_q          <= '0;
            zero_row_q     <= 1'b0;
            final_row_q    <= 1'b0;
            frame_end_q    <= 1'b0;
            t_q            <= '0;
            rd_q           <= '0;
            w0_q           <= '0;
            w1_q           <= '0;
            to_pad_q       <= '0;
            out_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            pix_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_col_q       <= wr_col_d;
            rows_written_q <= rows_written_d;
            r_base_q       <= r_base_d;
            row_q          <= row_d;
            zero_row_q     <= zero_row_d;
            final_row_q    <= final_row_d;
            frame_end_q    <= frame_end_d;
            t_q            <= t_d;
            rd_q           <= rd_d;
            w0_q           <= w0_d;
            w1_q           <= w1_d;
            to_pad_q       <= to_pad_d;
            out_valid_q    <= out_valid_d;
            frame_done_q   <= frame_done_d;
            pix_ready_q    <= pix_ready_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign to_pad     = to_pad_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_window_9_reg.sv
// Bench for window_9_reg on a 6x6 image: expected window words built from
// hand-filled pass/column tables, scoreboarded against every out_valid cycle.
module tb_window_9_reg;
    localparam int W    = 6;
    localparam int H    = 6;
    localparam int NWIN = W * H;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [109:0] to_pad;
    logic         out_valid;
    logic         frame_done;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    window_9_reg #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .to_pad     (to_pad),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    typedef struct { logic [14:0] r; logic zr; logic fr; } pass_t;
    typedef struct { logic [14:0] c; logic zc; logic fc; } col_t;
    typedef struct { logic [7:0] base; int idle_pct; bit bp_chk; bit drain; int exp_windows; } frame_vec_t;

    pass_t      pass_tab[H];
    col_t       col_tab[W];
    frame_vec_t vecs[4];

    logic [110:0] exp_q[$];
    logic [110:0] exp_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    bit  bp_active = 1'b0;
    int  win_cnt  = 0;
    int  fd_cnt   = 0;
    int  run_len  = 0;
    int  low_len  = 0;
    int  scan_age = 0;
    bit  seen_any = 1'b0;
    bit  prev_ov  = 1'b0;
    logic [1:0] prev_st = 2'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input int row, input int col);
        return base + 8'(row * 16 + col);
    endfunction

    task automatic push_frame(input logic [7:0] base);
        logic [71:0] d;
        for (int p = 0; p < H; p++) begin
            for (int k = 0; k < W; k++) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        d[71 - i*24 - j*8 -: 8] = pix(base, int'(pass_tab[p].r) + i, int'(col_tab[k].c) + j);
                    end
                end
                exp_q.push_back({pass_tab[p].r, col_tab[k].c, 4'b0000, pass_tab[p].zr, pass_tab[p].fr,
                                 col_tab[k].zc, col_tab[k].fc, d, ((p == H-1) && (k == W-1)) ? 1'b1 : 1'b0});
            end
        end
    endtask

    task automatic drive_pixels(input logic [7:0] base, input int first, input int last,
                                input int idle_pct, input bit bp_chk);
        int wt;
        for (int n = first; n <= last; n++) begin
            while ($urandom_range(0, 99) < idle_pct) begin
                pix_valid = 1'b0;
                @(posedge clk); #1;
            end
            pix_in    = pix(base, n / W, n % W);
            pix_valid = 1'b1;
            wt = 0;
            while (!pix_ready && wt < 1000) begin
                @(posedge clk); #1;
                wt++;
            end
            if (!pix_ready) begin
                check("pix_ready_timeout", 128'd0, 128'd1);
                pix_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (bp_chk && n == 23) check("bp_low_after_24_pixels", pix_ready, 1'b0);
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            run_len  = 0;
            low_len  = 0;
            scan_age = 0;
            seen_any = 1'b0;
            prev_ov  = 1'b0;
            prev_st  = 2'd0;
            win_cnt  = 0;
        end else begin
            if (dbg_state == 2'd1 && prev_st != 2'd1) scan_age = 0;
            else scan_age++;
            prev_st = dbg_state;
            if (out_valid) begin
                if (!prev_ov) begin
                    check("pass_latency", scan_age, 4);
                    if (seen_any) check("gap_ge_3", (low_len >= 3), 1'b1);
                    low_len = 0;
                end
                seen_any = 1'b1;
                run_len++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", {to_pad, frame_done}, 128'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("window", {to_pad, frame_done}, exp_e);
                end
                win_cnt++;
                if (bp_active && win_cnt == 11) check("bp_low_during_pass1", pix_ready, 1'b0);
                if (bp_active && win_cnt == 12) check("bp_release_after_pass1", pix_ready, 1'b1);
                if (frame_done) begin
                    check("frame_window_count", win_cnt, NWIN);
                    win_cnt = 0;
                    fd_cnt++;
                end
            end else begin
                if (prev_ov) check("pass_run_length", run_len, W);
                run_len = 0;
                low_len++;
                check("frame_done_idle", frame_done, 1'b0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int ov_cnt;
        int wt;
        pass_tab[0] = '{15'd0, 1'b0, 1'b0};
        pass_tab[1] = '{15'd0, 1'b1, 1'b0};
        pass_tab[2] = '{15'd1, 1'b1, 1'b0};
        pass_tab[3] = '{15'd2, 1'b1, 1'b0};
        pass_tab[4] = '{15'd3, 1'b1, 1'b0};
        pass_tab[5] = '{15'd3, 1'b1, 1'b1};
        col_tab[0]  = '{15'd0, 1'b0, 1'b0};
        col_tab[1]  = '{15'd0, 1'b1, 1'b0};
        col_tab[2]  = '{15'd1, 1'b1, 1'b0};
        col_tab[3]  = '{15'd2, 1'b1, 1'b0};
        col_tab[4]  = '{15'd3, 1'b1, 1'b0};
        col_tab[5]  = '{15'd3, 1'b1, 1'b1};
        // base, idle %, backpressure check, drain after, windows
        vecs[0] = '{8'h00, 0,  1'b1, 1'b1, NWIN};
        vecs[1] = '{8'h00, 30, 1'b0, 1'b1, NWIN};
        vecs[2] = '{8'h40, 0,  1'b0, 1'b0, NWIN};
        vecs[3] = '{8'h80, 0,  1'b0, 1'b1, NWIN};

        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_in    = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_pix_ready", pix_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_to_pad", to_pad, 110'd0);
        check("reset_frame_done", frame_done, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("pix_ready_after_reset", pix_ready, 1'b1);
        mon_en = 1'b1;

        for (int v = 0; v < 4; v++) begin
            push_frame(vecs[v].base);
            check("expected_windows_queued", exp_q.size() >= vecs[v].exp_windows, 1'b1);
            bp_active = vecs[v].bp_chk;
            drive_pixels(vecs[v].base, 0, NWIN - 1, vecs[v].idle_pct, vecs[v].bp_chk);
            if (vecs[v].drain) wait_drain();
            bp_active = 1'b0;
        end
        check("frame_done_count_4", fd_cnt, 4);

        // Reset in the middle of a frame while windows are streaming out.
        mon_en = 1'b0;
        drive_pixels(8'h20, 0, 29, 0, 1'b0);
        wt = 0;
        while (!out_valid && wt < 200) begin
            @(negedge clk);
            wt++;
        end
        check("pre_reset_window_active", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_to_pad", to_pad, 110'd0);
        check("async_reset_frame_done", frame_done, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("reset_hold_pix_ready", pix_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("pix_ready_after_mid_reset", pix_ready, 1'b1);
        mon_en = 1'b1;
        push_frame(8'h20);
        drive_pixels(8'h20, 0, 16, 0, 1'b0);
        ov_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("no_output_before_3_rows", ov_cnt, 0);
        drive_pixels(8'h20, 17, NWIN - 1, 0, 1'b0);
        wait_drain();
        check("frame_done_count_5", fd_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
